// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM-stage requester and the data memory.
// The requester takes the master side; the memory responder takes the slave side.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        R_Enable;
  logic        W_Enable;
  logic [1:0]  R_Width;
  logic [1:0]  W_Width;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        resp_valid;
  logic [31:0] ReadData;
  logic        resp_err;

  modport master (
    output req_valid, R_Enable, W_Enable,
    output R_Width, W_Width, Address, WriteData,
    input  req_ready, resp_valid, ReadData, resp_err
  );

  modport slave (
    input  req_valid, R_Enable, W_Enable,
    input  R_Width, W_Width, Address, WriteData,
    output req_ready, resp_valid, ReadData, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: one outstanding request, programmable wait states,
// little-endian byte/half/word access with sign-extended loads.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic                 Clk,
  input logic                 Reset,
  data_mem_responder_if.slave bus
);
  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_ren;
  logic          r_wen;
  logic [1:0]    r_rw;
  logic [1:0]    r_ww;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_access;
  logic [1:0]    w_width;
  logic          w_bad;
  logic          w_ld;
  logic          w_st;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_old;
  logic [31:0]   w_shift;
  logic [31:0]   w_ld_data;
  logic [31:0]   w_mask;
  logic [31:0]   w_st_data;
  logic          w_unused_addr;

  assign w_accept      = bus.req_valid & (r_state == S_IDLE);
  assign w_access      = (r_state == S_WAIT) & (r_cnt == 4'd0);
  assign w_unused_addr = ^bus.Address[31:AW+2];

  assign w_width = r_ren ? r_rw : r_ww;
  assign w_idx   = r_addr[AW+1:2];
  assign w_old   = r_mem[w_idx];
  assign w_shift = w_old >> {r_addr[1:0], 3'b000};

  // Both enables set is rejected regardless of the width fields.
  always_comb begin
    w_bad = 1'b0;
    if (r_ren & r_wen) begin
      w_bad = 1'b1;
    end else if (r_ren | r_wen) begin
      unique case (w_width)
        2'd0:    w_bad = (r_addr[1:0] != 2'd0);
        2'd1:    w_bad = r_addr[0];
        2'd2:    w_bad = 1'b0;
        default: w_bad = 1'b1;
      endcase
    end
  end

  assign w_ld = r_ren & ~r_wen & ~w_bad;
  assign w_st = r_wen & ~r_ren & ~w_bad;

  always_comb begin
    w_ld_data = '0;
    w_mask    = '0;
    w_st_data = '0;
    unique case (w_width)
      2'd0: begin
        w_ld_data = w_old;
        w_mask    = 32'hFFFF_FFFF;
        w_st_data = r_wdata;
      end
      2'd1: begin
        w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
        w_mask    = 32'h0000_FFFF << {r_addr[1], 4'b0000};
        w_st_data = {2{r_wdata[15:0]}};
      end
      2'd2: begin
        w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
        w_mask    = 32'h0000_00FF << {r_addr[1:0], 3'b000};
        w_st_data = {4{r_wdata[7:0]}};
      end
      default: begin
        w_ld_data = '0;
        w_mask    = '0;
        w_st_data = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_cnt   <= LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= w_ld ? w_ld_data : 32'd0;
            r_err   <= w_bad;
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request copy is private to the transaction; later input changes are ignored.
  always_ff @(posedge Clk) begin
    if (!Reset && w_accept) begin
      r_ren   <= bus.R_Enable;
      r_wen   <= bus.W_Enable;
      r_rw    <= bus.R_Width;
      r_ww    <= bus.W_Width;
      r_addr  <= bus.Address[AW+1:0];
      r_wdata <= bus.WriteData;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && w_access && w_st) begin
      r_mem[w_idx] <= (w_old & ~w_mask) | (w_st_data & w_mask);
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.ReadData   = r_rdata;
  assign bus.resp_err   = r_err;
endmodule
